// File: rtl/pc_pkg.sv
// Shared definitions for the picoMIPS program-counter sequencer.
// Contents:
//   pc_state_t - sequencer FSM states (RUN, HALT)
//   PSIZE_DEF  - default address width, must match prog.Psize
//   DEPTH_DEF  - default number of return-stack entries
//   pc_incr    - PC + 1 with wrap-around at 2^Psize
package pc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

    localparam int unsigned PSIZE_DEF = 32'd4;
    localparam int unsigned DEPTH_DEF = 32'd2;

    // Sequential successor of an address; the carry out is dropped so the
    // top address wraps to zero.
    function automatic logic [PSIZE_DEF-1:0] pc_incr(input logic [PSIZE_DEF-1:0] pc);
        return pc + {{(PSIZE_DEF-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control/address bundle between the picoMIPS decoder and the PC sequencer.
// Signals:
//   stall, branch, jump, call, ret, halt_req, resume - control requests
//   Branchaddr - jump/call target or two's-complement branch offset
//   PCout      - current instruction address (to prog.address)
//   halted     - high while the sequencer is in HALT
//   stack_err  - sticky return-stack overflow/underflow flag
// Modports: master drives the requests, slave is the sequencer.
interface pc_seq_if
    import pc_pkg::*;
#(
    parameter int Psize = PSIZE_DEF
);
    logic             stall;
    logic             branch;
    logic             jump;
    logic             call;
    logic             ret;
    logic             halt_req;
    logic             resume;
    logic [Psize-1:0] Branchaddr;
    logic [Psize-1:0] PCout;
    logic             halted;
    logic             stack_err;

    modport master (
        output stall, branch, jump, call, ret, halt_req, resume, Branchaddr,
        input  PCout, halted, stack_err
    );

    modport slave (
        input  stall, branch, jump, call, ret, halt_req, resume, Branchaddr,
        output PCout, halted, stack_err
    );

endinterface

// File: rtl/pc_seq_ret_stack.sv
// ret_stack: synchronous LIFO holding call return addresses.
// Ports:
//   clk, reset - clock and synchronous active-high reset (empties the stack)
//   push, din  - store din on top (ignored when full)
//   pop        - discard the top entry (ignored when empty)
//   top        - current top entry (zero when empty)
//   full/empty - occupancy flags
// The caller never asserts push and pop in the same cycle.
module ret_stack
    import pc_pkg::*;
#(
    parameter int Psize = PSIZE_DEF,
    parameter int Depth = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Psize-1:0] din,
    output logic [Psize-1:0] top,
    output logic             full,
    output logic             empty
);

    // Stack pointer counts 0..Depth; storage is indexed with just enough bits
    // to address Depth entries (rounded up to a power of two).
    localparam int SPW   = $clog2(Depth + 1);
    localparam int IW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int SLOTS = 2 ** IW;

    logic [Psize-1:0] mem_r [SLOTS];
    logic [SPW-1:0]   sp_r;
    logic [SPW-1:0]   sp_m1_s;

    assign full    = (sp_r == SPW'(Depth));
    assign empty   = (sp_r == {SPW{1'b0}});
    assign sp_m1_s = sp_r - {{(SPW-1){1'b0}}, 1'b1};

    // Top-of-stack read, forced to zero when nothing is stored.
    always_comb begin
        top = {Psize{1'b0}};
        if (!empty) begin
            top = mem_r[sp_m1_s[IW-1:0]];
        end else begin
            top = {Psize{1'b0}};
        end
    end

    // Pointer and storage update; reset clears every slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_r <= {SPW{1'b0}};
            for (int i = 0; i < SLOTS; i++) begin
                mem_r[i] <= {Psize{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[sp_r[IW-1:0]] <= din;
            sp_r                <= sp_r + {{(SPW-1){1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            sp_r <= sp_m1_s;
        end else begin
            sp_r <= sp_r;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer feeding the picoMIPS program ROM.
// Ports:
//   clk   - system clock, all state changes on its rising edge
//   reset - synchronous active-high reset
//   bus   - pc_seq_if slave: control requests and Branchaddr in,
//           PCout / halted / stack_err out (all registered)
// RUN-state priority: halt_req > stall > ret > call > jump > branch > increment.
module pc_seq
    import pc_pkg::*;
#(
    parameter int Psize = PSIZE_DEF,
    parameter int Depth = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    pc_seq_if.slave      bus
);

    pc_state_t        state_r;
    logic [Psize-1:0] pc_r;
    logic             halted_r;
    logic             err_r;

    logic [Psize-1:0] pc_inc_s;
    logic [Psize-1:0] next_pc_s;
    logic             push_s;
    logic             pop_s;
    logic             set_err_s;
    logic [Psize-1:0] top_s;
    logic             full_s;
    logic             empty_s;

    assign pc_inc_s = pc_r + {{(Psize-1){1'b0}}, 1'b1};

    ret_stack #(
        .Psize (Psize),
        .Depth (Depth)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (pc_inc_s),
        .top   (top_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-PC mux and stack requests; only an active, unstalled RUN cycle
    // without halt_req may move the PC or touch the stack.
    always_comb begin
        next_pc_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        set_err_s = 1'b0;
        if ((state_r == RUN) && !bus.halt_req && !bus.stall) begin
            if (bus.ret) begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    next_pc_s = top_s;
                end else begin
                    set_err_s = 1'b1;
                    next_pc_s = pc_inc_s;
                end
            end else if (bus.call) begin
                if (!full_s) begin
                    push_s    = 1'b1;
                    next_pc_s = bus.Branchaddr;
                end else begin
                    set_err_s = 1'b1;
                    next_pc_s = pc_inc_s;
                end
            end else if (bus.jump) begin
                next_pc_s = bus.Branchaddr;
            end else if (bus.branch) begin
                // Modular add: a negative offset wraps downward for free.
                next_pc_s = pc_r + bus.Branchaddr;
            end else begin
                next_pc_s = pc_inc_s;
            end
        end else begin
            next_pc_s = pc_r;
        end
    end

    // RUN/HALT state machine with registered PC, halted and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= RUN;
            pc_r     <= {Psize{1'b0}};
            halted_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.halt_req) begin
                        state_r  <= HALT;
                        halted_r <= 1'b1;
                    end else begin
                        pc_r  <= next_pc_s;
                        err_r <= err_r | set_err_s;
                    end
                end
                HALT: begin
                    // PC holds through the resume cycle as well.
                    if (bus.resume) begin
                        state_r  <= RUN;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= HALT;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCout     = pc_r;
    assign bus.halted    = halted_r;
    assign bus.stack_err = err_r;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: a directed vector table covering the
// documented corner cases, then randomized traffic against a queue-based
// behavioural model.
module tb_pc_seq;

    logic clk;
    logic reset;

    pc_seq_if #(.Psize(4)) bus ();

    pc_seq #(.Psize(4), .Depth(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, stl, br, jp, cl, rt, hr, rs;
        logic [3:0] addr;
        logic [3:0] epc;
        logic       eh, ee;
    } vec_t;

    vec_t vecs[$];
    int   ntests = 0;
    int   nfail  = 0;

    function automatic void add(input logic rst, input logic stl, input logic br,
                                input logic jp, input logic cl, input logic rt,
                                input logic hr, input logic rs, input int addr,
                                input int epc, input logic eh, input logic ee);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.jp = jp; v.cl = cl; v.rt = rt;
        v.hr = hr; v.rs = rs; v.addr = 4'(addr); v.epc = 4'(epc); v.eh = eh; v.ee = ee;
        vecs.push_back(v);
    endfunction

    // Apply one cycle of inputs and check the registered outputs after the edge.
    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        reset          = v.rst;
        bus.stall      = v.stl;
        bus.branch     = v.br;
        bus.jump       = v.jp;
        bus.call       = v.cl;
        bus.ret        = v.rt;
        bus.halt_req   = v.hr;
        bus.resume     = v.rs;
        bus.Branchaddr = v.addr;
        @(posedge clk);
        #1;
        ntests++;
        if (bus.PCout !== v.epc || bus.halted !== v.eh || bus.stack_err !== v.ee) begin
            nfail++;
            $display("FAIL %s[%0d] got pc=%0d halted=%0b err=%0b, expected pc=%0d halted=%0b err=%0b",
                     tag, idx, bus.PCout, bus.halted, bus.stack_err, v.epc, v.eh, v.ee);
        end
    endtask

    // Behavioural reference state
    int  m_pc;
    bit  m_halted;
    bit  m_err;
    int  m_stack[$];

    initial begin
        reset = 1'b0;
        bus.stall = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0; bus.call = 1'b0;
        bus.ret = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0; bus.Branchaddr = 4'd0;

        // ---------------- directed table ----------------
        //   rst stl br jp cl rt hr rs addr  pc h e
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0);
        for (int i = 1; i <= 16; i++) add(0,0,0,0,0,0,0,0, 0, i % 16, 0, 0);
        for (int i = 1; i <= 3; i++)  add(0,0,0,0,0,0,0,0, 0, i, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 14,   1, 0, 0);   // 3 + (-2)
        for (int i = 2; i <= 14; i++) add(0,0,0,0,0,0,0,0, 0, i, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 3,    1, 0, 0);   // 14 + 3 wraps
        for (int i = 2; i <= 5; i++)  add(0,0,0,0,0,0,0,0, 0, i, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 10,  10, 0, 0);   // push 6
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   11, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   12, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 2,    2, 0, 0);   // push 13
        add(0, 0, 0, 0, 1, 0, 0, 0, 7,    3, 0, 1);   // overflow
        add(0, 0, 0, 0, 0, 1, 0, 0, 0,   13, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0,    6, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0,    7, 0, 1);   // underflow
        add(0, 0, 0, 1, 0, 0, 1, 0, 0,    7, 1, 1);   // halt wins over jump
        for (int k = 0; k < 5; k++) add(0,0,0,k % 2,1,0,1,0, 3, 7, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0,    7, 0, 1);   // resume: hold one cycle
        add(0, 0, 0, 0, 0, 0, 0, 1, 0,    8, 0, 1);   // resume in RUN ignored
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,    9, 0, 1);
        for (int k = 0; k < 3; k++) add(0,1,0,0,1,0,0,0, 4, 9, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 4,    4, 0, 1);   // push 10
        add(0, 0, 0, 0, 0, 1, 0, 0, 0,   10, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 12,  12, 0, 1);   // push 11
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,   12, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0);   // reset in HALT
        add(0, 0, 0, 0, 0, 1, 0, 0, 0,    1, 0, 1);   // stack was emptied
        add(1, 0, 0, 0, 1, 0, 0, 0, 5,    0, 0, 0);   // reset beats call
        add(0, 0, 0, 0, 0, 1, 0, 0, 0,    1, 0, 1);   // nothing was pushed
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 9,    9, 0, 0);   // jump
        add(0, 0, 1, 1, 0, 0, 0, 0, 6,    6, 0, 0);   // jump beats branch
        add(0, 0, 1, 0, 0, 0, 0, 0, 15,   5, 0, 0);   // branch -1

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "vec", i);

        // ---------------- randomized vs model ----------------
        m_pc = 0; m_halted = 1'b0; m_err = 1'b0; m_stack.delete();
        begin
            vec_t v;
            v.rst = 1'b1; v.stl = 0; v.br = 0; v.jp = 0; v.cl = 0; v.rt = 0;
            v.hr = 0; v.rs = 0; v.addr = 4'd0; v.epc = 4'd0; v.eh = 0; v.ee = 0;
            apply(v, "rnd", -1);
        end
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            int   off;
            v.rst  = ($urandom_range(0, 79) == 0);
            v.stl  = ($urandom_range(0, 7) == 0);
            v.br   = ($urandom_range(0, 3) == 0);
            v.jp   = ($urandom_range(0, 5) == 0);
            v.cl   = ($urandom_range(0, 4) == 0);
            v.rt   = ($urandom_range(0, 4) == 0);
            v.hr   = ($urandom_range(0, 11) == 0);
            v.rs   = ($urandom_range(0, 2) == 0);
            v.addr = 4'($urandom_range(0, 15));

            if (v.rst) begin
                m_pc = 0; m_halted = 1'b0; m_err = 1'b0; m_stack.delete();
            end else if (m_halted) begin
                if (v.rs) m_halted = 1'b0;
            end else if (v.hr) begin
                m_halted = 1'b1;
            end else if (v.stl) begin
                // hold
            end else if (v.rt) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_err = 1'b1; m_pc = (m_pc + 1) % 16; end
            end else if (v.cl) begin
                if (m_stack.size() < 2) begin
                    m_stack.push_back((m_pc + 1) % 16);
                    m_pc = int'(v.addr);
                end else begin
                    m_err = 1'b1; m_pc = (m_pc + 1) % 16;
                end
            end else if (v.jp) begin
                m_pc = int'(v.addr);
            end else if (v.br) begin
                off  = (v.addr >= 4'd8) ? int'(v.addr) - 16 : int'(v.addr);
                m_pc = (m_pc + off + 16) % 16;
            end else begin
                m_pc = (m_pc + 1) % 16;
            end
            v.epc = 4'(m_pc);
            v.eh  = m_halted;
            v.ee  = m_err;
            apply(v, "rnd", n);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
